// File: rtl/opmips_defs_pkg.sv
// Shared definitions for the MIPS32 pipeline: widths, control constants,
// ALU operation codes, result classes and the multiplier state type.
package opmips_defs_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic RST_ENABLE    = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  // AluOp codes
  localparam logic [7:0] EXE_NOP_OP   = 8'h00;
  localparam logic [7:0] EXE_OR_OP    = 8'h25;
  localparam logic [7:0] EXE_AND_OP   = 8'h24;
  localparam logic [7:0] EXE_XOR_OP   = 8'h26;
  localparam logic [7:0] EXE_NOR_OP   = 8'h27;
  localparam logic [7:0] EXE_SLL_OP   = 8'h7C;
  localparam logic [7:0] EXE_SRL_OP   = 8'h02;
  localparam logic [7:0] EXE_SRA_OP   = 8'h03;
  localparam logic [7:0] EXE_MFHI_OP  = 8'h10;
  localparam logic [7:0] EXE_MFLO_OP  = 8'h12;
  localparam logic [7:0] EXE_MULT_OP  = 8'h18;
  localparam logic [7:0] EXE_MULTU_OP = 8'h19;

  // AluSel result classes
  localparam logic [2:0] EXE_RES_NOP   = 3'd0;
  localparam logic [2:0] EXE_RES_LOGIC = 3'd1;
  localparam logic [2:0] EXE_RES_SHIFT = 3'd2;
  localparam logic [2:0] EXE_RES_MOVE  = 3'd3;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_serial.sv
// Iterative shift-add multiplier. Signed operation multiplies magnitudes and
// fixes the sign of the double-width product at the end.
module mul_serial
  import opmips_defs_pkg::*;
#(
  parameter int W = DATA_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           is_signed,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(W);

  mul_state_t       state_r, state_s;
  logic [W-1:0]     mcand_r, mplier_r;
  logic [2*W-1:0]   acc_r;
  logic [CW-1:0]    cnt_r;
  logic             neg_r;
  logic [W-1:0]     abs_a_s, abs_b_s;
  logic [2*W-1:0]   addend_s;
  logic             last_s;

  assign abs_a_s  = (is_signed && a[W-1]) ? (~a + W'(1)) : a;
  assign abs_b_s  = (is_signed && b[W-1]) ? (~b + W'(1)) : b;
  assign addend_s = {{W{1'b0}}, mcand_r} << cnt_r;
  assign last_s   = (cnt_r == CW'(W - 1));
  assign done     = (state_r == MUL_DONE);
  assign product  = neg_r ? (~acc_r + (2*W)'(1)) : acc_r;

  // State register
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_r <= MUL_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and busy; a start seen in DONE is ignored because DONE always returns to IDLE
  always_comb begin
    state_s = state_r;
    busy    = 1'b0;
    case (state_r)
      MUL_IDLE: begin
        if (start) begin
          state_s = MUL_RUN;
          busy    = 1'b1;
        end else begin
          state_s = MUL_IDLE;
        end
      end
      MUL_RUN: begin
        busy = 1'b1;
        if (last_s) begin
          state_s = MUL_DONE;
        end else begin
          state_s = MUL_RUN;
        end
      end
      MUL_DONE: begin
        state_s = MUL_IDLE;
      end
      default: begin
        state_s = MUL_IDLE;
      end
    endcase
  end

  // Operand latch and one shift-add step per RUN cycle
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      mcand_r  <= {W{1'b0}};
      mplier_r <= {W{1'b0}};
      acc_r    <= {(2*W){1'b0}};
      cnt_r    <= {CW{1'b0}};
      neg_r    <= 1'b0;
    end else begin
      case (state_r)
        MUL_IDLE: begin
          if (start) begin
            mcand_r  <= abs_a_s;
            mplier_r <= abs_b_s;
            acc_r    <= {(2*W){1'b0}};
            cnt_r    <= {CW{1'b0}};
            neg_r    <= is_signed & (a[W-1] ^ b[W-1]);
          end else begin
            cnt_r <= cnt_r;
          end
        end
        MUL_RUN: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + addend_s;
          end else begin
            acc_r <= acc_r;
          end
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CW'(1);
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational logic/shift/move result path plus the
// iterative multiplier that owns HI/LO and stalls the front of the pipe.
module ex_stage
  import opmips_defs_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int REG_AW = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        aluop_i,
  input  logic [2:0]        alusel_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [REG_AW-1:0] wd_i,
  input  logic              wreg_i,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              stallreq_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int SH_W = $clog2(DATA_W);

  logic                is_mul_s, is_signed_s, mul_busy_s, mul_done_s;
  logic [2*DATA_W-1:0] mul_prod_s;
  logic [DATA_W-1:0]   hi_r, lo_r;
  logic [DATA_W-1:0]   logic_res_s, shift_res_s, move_res_s, result_s;
  logic [SH_W-1:0]     shamt_s;

  assign is_mul_s    = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP);
  assign is_signed_s = (aluop_i == EXE_MULT_OP);
  assign shamt_s     = reg1_i[SH_W-1:0];

  mul_serial #(.W(DATA_W)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start     (is_mul_s),
    .is_signed (is_signed_s),
    .a         (reg1_i),
    .b         (reg2_i),
    .busy      (mul_busy_s),
    .done      (mul_done_s),
    .product   (mul_prod_s)
  );

  // HI/LO capture the finished product on the DONE edge
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      hi_r <= {DATA_W{1'b0}};
      lo_r <= {DATA_W{1'b0}};
    end else if (mul_done_s) begin
      hi_r <= mul_prod_s[2*DATA_W-1:DATA_W];
      lo_r <= mul_prod_s[DATA_W-1:0];
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  // Logic-class results
  always_comb begin
    logic_res_s = {DATA_W{1'b0}};
    case (aluop_i)
      EXE_OR_OP:  logic_res_s = reg1_i | reg2_i;
      EXE_AND_OP: logic_res_s = reg1_i & reg2_i;
      EXE_XOR_OP: logic_res_s = reg1_i ^ reg2_i;
      EXE_NOR_OP: logic_res_s = ~(reg1_i | reg2_i);
      default:    logic_res_s = {DATA_W{1'b0}};
    endcase
  end

  // Shift-class results; only the low shift-amount bits of operand 1 matter
  always_comb begin
    shift_res_s = {DATA_W{1'b0}};
    case (aluop_i)
      EXE_SLL_OP: shift_res_s = reg2_i << shamt_s;
      EXE_SRL_OP: shift_res_s = reg2_i >> shamt_s;
      EXE_SRA_OP: shift_res_s = DATA_W'($signed(reg2_i) >>> shamt_s);
      default:    shift_res_s = {DATA_W{1'b0}};
    endcase
  end

  // Move-class results read the HI/LO registers
  always_comb begin
    move_res_s = {DATA_W{1'b0}};
    case (aluop_i)
      EXE_MFHI_OP: move_res_s = hi_r;
      EXE_MFLO_OP: move_res_s = lo_r;
      default:     move_res_s = {DATA_W{1'b0}};
    endcase
  end

  // Result class select
  always_comb begin
    result_s = {DATA_W{1'b0}};
    case (alusel_i)
      EXE_RES_LOGIC: result_s = logic_res_s;
      EXE_RES_SHIFT: result_s = shift_res_s;
      EXE_RES_MOVE:  result_s = move_res_s;
      default:       result_s = {DATA_W{1'b0}};
    endcase
  end

  // Output drive; everything reads zero while reset is held
  always_comb begin
    wd_o       = {REG_AW{1'b0}};
    wreg_o     = WRITE_DISABLE;
    wdata_o    = {DATA_W{1'b0}};
    stallreq_o = 1'b0;
    hi_o       = {DATA_W{1'b0}};
    lo_o       = {DATA_W{1'b0}};
    if (rst == RST_ENABLE) begin
      wd_o = {REG_AW{1'b0}};
    end else begin
      wd_o       = wd_i;
      wreg_o     = is_mul_s ? WRITE_DISABLE : wreg_i;
      wdata_o    = result_s;
      stallreq_o = mul_busy_s;
      hi_o       = hi_r;
      lo_o       = lo_r;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed table, multiplier sequences,
// and randomized operations against a behavioural model.
module tb_ex_stage;

  localparam logic [7:0] OP_NOP = 8'h00, OP_OR = 8'h25, OP_AND = 8'h24, OP_XOR = 8'h26;
  localparam logic [7:0] OP_NOR = 8'h27, OP_SLL = 8'h7C, OP_SRL = 8'h02, OP_SRA = 8'h03;
  localparam logic [7:0] OP_MFHI = 8'h10, OP_MFLO = 8'h12, OP_MULT = 8'h18, OP_MULTU = 8'h19;
  localparam logic [2:0] S_NOP = 3'd0, S_LOG = 3'd1, S_SH = 3'd2, S_MOV = 3'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [31:0] reg1, reg2;
  logic [4:0]  wd;
  logic        wreg;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o, hi_o, lo_o;
  logic        stall_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .aluop_i(aluop), .alusel_i(alusel),
    .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stallreq_o(stall_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Behavioural result: shifts as multiply/divide by powers of two
  function automatic logic [31:0] ref_wdata(input logic [7:0] op, input logic [2:0] sel,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] hi, input logic [31:0] lo);
    logic [63:0] pw, wide;
    logic [31:0] r;
    pw = 64'd1 << a[4:0];
    r  = 32'd0;
    if (sel == S_LOG) begin
      if (op == OP_OR) r = a | b;
      else if (op == OP_AND) r = a & b;
      else if (op == OP_XOR) r = a ^ b;
      else if (op == OP_NOR) r = ~(a | b);
    end else if (sel == S_SH) begin
      if (op == OP_SLL) begin
        wide = {32'd0, b} * pw; r = wide[31:0];
      end else if (op == OP_SRL) begin
        wide = {32'd0, b} / pw; r = wide[31:0];
      end else if (op == OP_SRA) begin
        if (b[31]) begin
          wide = {32'd0, ~b} / pw; r = ~wide[31:0];
        end else begin
          wide = {32'd0, b} / pw; r = wide[31:0];
        end
      end
    end else if (sel == S_MOV) begin
      if (op == OP_MFHI) r = hi;
      else if (op == OP_MFLO) r = lo;
    end
    return r;
  endfunction

  function automatic logic [63:0] ref_prod(input logic [7:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sa, sb;
    if (op == OP_MULT) begin
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d, input logic w);
    @(negedge clk);
    aluop = op; alusel = sel; reg1 = a; reg2 = b; wd = d; wreg = w;
    #1;
  endtask

  // Issue a multiply, measure the stall window, then update the HI/LO model.
  // Returns in the DONE cycle so the caller can issue the next instruction.
  task automatic run_mult(input string name, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    logic [63:0] p;
    int n;
    p = ref_prod(op, a, b);
    drive(op, S_NOP, a, b, 5'd9, 1'b1);
    chk({name, "_hi_before"}, hi_o, hi_m);
    chk({name, "_lo_before"}, lo_o, lo_m);
    chk({name, "_stall_first"}, stall_o, 1'b1);
    chk({name, "_wreg_forced"}, wreg_o, 1'b0);
    n = 0;
    while (stall_o === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk({name, "_stall_len"}, 64'(n), 64'd33);
    chk({name, "_done_wreg"}, wreg_o, 1'b0);
    hi_m = p[63:32];
    lo_m = p[31:0];
  endtask

  initial begin
    tbl[0]  = '{OP_OR,  S_LOG, 32'h0000FF00, 32'h00F0000F, 5'd5,  1'b1, 32'h00F0FF0F};
    tbl[1]  = '{OP_AND, S_LOG, 32'hFF00FF00, 32'h0F0F0F0F, 5'd1,  1'b1, 32'h0F000F00};
    tbl[2]  = '{OP_XOR, S_LOG, 32'hFFFF0000, 32'h0F0F0F0F, 5'd2,  1'b1, 32'hF0F00F0F};
    tbl[3]  = '{OP_NOR, S_LOG, 32'h0000FFFF, 32'h00FF0000, 5'd3,  1'b0, 32'hFF000000};
    tbl[4]  = '{OP_SRA, S_SH,  32'h00000004, 32'h80000010, 5'd4,  1'b1, 32'hF8000001};
    tbl[5]  = '{OP_SRL, S_SH,  32'h00000004, 32'h80000010, 5'd6,  1'b1, 32'h08000001};
    tbl[6]  = '{OP_SLL, S_SH,  32'h00000025, 32'h00000010, 5'd7,  1'b1, 32'h00000200};
    tbl[7]  = '{OP_SRA, S_SH,  32'h00000000, 32'h80000010, 5'd8,  1'b1, 32'h80000010};
    tbl[8]  = '{OP_SLL, S_SH,  32'hFFFFFFE0, 32'h12345678, 5'd10, 1'b1, 32'h12345678};
    tbl[9]  = '{OP_SRA, S_SH,  32'h0000001F, 32'h80000000, 5'd11, 1'b1, 32'hFFFFFFFF};
    tbl[10] = '{OP_SRL, S_SH,  32'h0000001F, 32'h80000000, 5'd12, 1'b1, 32'h00000001};
    tbl[11] = '{OP_OR,  S_SH,  32'h12340000, 32'h00005678, 5'd13, 1'b1, 32'h00000000};
    tbl[12] = '{OP_SLL, S_LOG, 32'h00000001, 32'h00000001, 5'd14, 1'b1, 32'h00000000};
    tbl[13] = '{OP_NOP, S_NOP, 32'hAAAAAAAA, 32'h55555555, 5'd15, 1'b0, 32'h00000000};
    tbl[14] = '{OP_OR,  3'd7,  32'hAAAAAAAA, 32'h55555555, 5'd31, 1'b1, 32'h00000000};

    // Reset holds every output at zero even with live inputs
    rst = 1'b1;
    aluop = OP_OR; alusel = S_LOG; reg1 = 32'h1234; reg2 = 32'h5678; wd = 5'd5; wreg = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_wd", wd_o, 5'd0);
    chk("rst_wreg", wreg_o, 1'b0);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    aluop = OP_MULT; #1;
    chk("rst_stall", stall_o, 1'b0);
    @(negedge clk);
    rst = 1'b0; aluop = OP_NOP; alusel = S_NOP;

    // Directed table
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].op, tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].wd, tbl[i].wreg);
      chk($sformatf("tbl%0d_wdata", i), wdata_o, tbl[i].exp);
      chk($sformatf("tbl%0d_wd", i), wd_o, tbl[i].wd);
      chk($sformatf("tbl%0d_wreg", i), wreg_o, tbl[i].wreg);
      chk($sformatf("tbl%0d_stall", i), stall_o, 1'b0);
    end

    // Signed multiply with a negative operand, then MFLO/MFHI with no stall
    run_mult("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd5);
    drive(OP_MFLO, S_MOV, 32'd0, 32'd0, 5'd3, 1'b1);
    chk("mflo_wdata", wdata_o, 32'hFFFFFFF1);
    chk("mflo_stall", stall_o, 1'b0);
    chk("mflo_wreg", wreg_o, 1'b1);
    drive(OP_MFHI, S_MOV, 32'd0, 32'd0, 5'd4, 1'b1);
    chk("mfhi_wdata", wdata_o, 32'hFFFFFFFF);

    run_mult("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    drive(OP_NOP, S_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    chk("multu_hi", hi_o, 32'hFFFFFFFE);
    chk("multu_lo", lo_o, 32'h00000001);

    run_mult("mult_min", OP_MULT, 32'h80000000, 32'hFFFFFFFF);
    drive(OP_NOP, S_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    chk("mult_min_hi", hi_o, 32'h00000000);
    chk("mult_min_lo", lo_o, 32'h80000000);

    // Reset at RUN cycle 10 aborts the multiply and clears HI/LO
    drive(OP_MULT, S_NOP, 32'd9, 32'd9, 5'd1, 1'b1);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("abort_stall_rst", stall_o, 1'b0);
    chk("abort_hi", hi_o, 32'd0);
    chk("abort_lo", lo_o, 32'd0);
    rst = 1'b0; aluop = OP_NOP; #1;
    chk("abort_stall_idle", stall_o, 1'b0);
    hi_m = 32'd0; lo_m = 32'd0;
    repeat (25) @(negedge clk);
    #1;
    chk("abort_lo_later", lo_o, 32'd0);
    run_mult("mult_after_abort", OP_MULT, 32'd2, 32'd3);
    drive(OP_NOP, S_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    chk("after_abort_lo", lo_o, 32'd6);

    // Back-to-back multiplies separated by only the DONE cycle
    run_mult("b2b_first", OP_MULT, 32'd7, 32'd6);
    run_mult("b2b_second", OP_MULT, 32'd2, 32'd2);
    drive(OP_NOP, S_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    chk("b2b_hi", hi_o, 32'd0);
    chk("b2b_lo", lo_o, 32'd4);

    // Random multiplies checked via the HI/LO model
    for (int i = 0; i < 4; i++) begin
      run_mult($sformatf("rmul%0d", i), (i % 2 == 0) ? OP_MULT : OP_MULTU, $urandom, $urandom);
      drive(OP_NOP, S_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
      chk($sformatf("rmul%0d_hi", i), hi_o, hi_m);
      chk($sformatf("rmul%0d_lo", i), lo_o, lo_m);
    end

    // Random single-cycle operations against the model
    for (int i = 0; i < 300; i++) begin
      logic [7:0]  op;
      logic [2:0]  sel;
      logic [31:0] a, b;
      logic [4:0]  d;
      logic        w;
      case ($urandom_range(0, 10))
        0: op = OP_OR;   1: op = OP_AND;  2: op = OP_XOR; 3: op = OP_NOR;
        4: op = OP_SLL;  5: op = OP_SRL;  6: op = OP_SRA; 7: op = OP_MFHI;
        8: op = OP_MFLO; 9: op = OP_NOP;
        default: begin
          op = 8'($urandom);
          if (op == OP_MULT || op == OP_MULTU) op = OP_NOP;
        end
      endcase
      sel = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 3));
      a = $urandom; b = $urandom; d = 5'($urandom); w = 1'($urandom);
      drive(op, sel, a, b, d, w);
      chk($sformatf("rnd%0d_wdata", i), wdata_o, ref_wdata(op, sel, a, b, hi_m, lo_m));
      chk($sformatf("rnd%0d_wd", i), wd_o, d);
      chk($sformatf("rnd%0d_wreg", i), wreg_o, w);
      chk($sformatf("rnd%0d_stall", i), stall_o, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS32 pipeline. Consumes the decoded operation (aluop/alusel/operands/destination) from the ID/EX register.
- Produces the write-back triple (wd/wreg/wdata), which feeds both the EX/MEM register and the ID-stage forwarding inputs.
- Adds an iterative 32x32 multiplier (MULT/MULTU) with internal HI/LO registers. The multiplier raises a pipeline stall request while it runs.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- aluop_i  in  8  operation code (package constants).
- alusel_i  in  3  result class (package constants).
- reg1_i  in  DATA_W  operand 1 (shift amount in [4:0] for shifts).
- reg2_i  in  DATA_W  operand 2 (value to shift).
- wd_i  in  REG_AW  destination register.
- wreg_i  in  1  destination write enable.
- wd_o  out  REG_AW  destination to EX/MEM and ID forwarding.
- wreg_o  out  1  write enable to EX/MEM and ID forwarding.
- wdata_o  out  DATA_W  result to EX/MEM and ID forwarding.
- stallreq_o  out  1  freezes PC, IF/ID and ID/EX while high.
- hi_o  out  DATA_W  HI register (debug/observation).
- lo_o  out  DATA_W  LO register (debug/observation).

Behaviour:
- Reset: while rst=1, all outputs are 0.
  - HI/LO=0, FSM=IDLE, counter=0, partial product=0.
  - Reset mid-multiply aborts the operation; HI/LO are not updated.
- Result path is combinational from the inputs; it is not registered here.
  - wd_o=wd_i.
  - wreg_o=wreg_i, except forced 0 for MULT/MULTU.
  - wdata_o is selected by alusel_i.
- RES_LOGIC (001): OR=a|b, AND=a&b, XOR=a^b, NOR=~(a|b).
- RES_SHIFT (010): SLL=b<<a[4:0], SRL=logical b>>a[4:0], SRA=arithmetic b>>>a[4:0].
  - Only a[4:0] is used; a shift amount of 0 returns b unchanged.
- RES_MOVE (011): MFHI=hi, MFLO=lo.
- RES_NOP (000), or an aluop not belonging to the selected class: wdata_o=0.
- Multiplier FSM:
  - IDLE: when aluop_i is MULT or MULTU:
    - stallreq_o=1 combinationally.
    - On the next edge, latch |reg1_i| and |reg2_i| (raw operands for MULTU) and the product sign (reg1[31]^reg2[31], signed only).
    - Clear the product and counter=0, then go to RUN.
  - RUN: stallreq_o=1.
    - Each cycle: one shift-add step (if multiplier LSB=1, add multiplicand<<counter), shift the multiplier right, counter++.
    - After the step with counter=31, go to DONE.
  - DONE: stallreq_o=0, so the pipeline advances at this edge.
    - Write HI/LO = 64-bit product, two's-complement negated if the sign is set.
    - Go to IDLE. The MULT still present on the inputs during DONE must not restart the FSM.
- Timing: stallreq_o is high for exactly 33 consecutive cycles (1 IDLE-detect + 32 RUN).
  - A MULT therefore occupies EX for 34 cycles.
  - An MFHI/MFLO in the next instruction reads the updated HI/LO with no extra stall.
- Abs of 0x80000000 is 0x80000000 treated as unsigned; no overflow handling is required.
- stallreq_o is 0 in all states other than those listed.

Decomposition:
- Package opmips_defs_pkg holds:
  - AluOp values: NOP 8'h00, OR 8'h25, AND 8'h24, XOR 8'h26, NOR 8'h27, SLL 8'h7C, SRL 8'h02, SRA 8'h03, MFHI 8'h10, MFLO 8'h12, MULT 8'h18, MULTU 8'h19.
  - AluSel values: NOP 0, LOGIC 1, SHIFT 2, MOVE 3.
  - Widths, and RstEnable/WriteEnable constants.
- One sub-module, mul_serial, is natural. It contains:
  - the FSM, counter, operand/product registers and sign fix-up;
  - interface: start, signed, a, b, busy, done, product[63:0].

Test Plan:
- OR, a=0x0000FF00, b=0x00F0000F, wd=5, wreg=1 -> same cycle wdata=0x00F0FF0F, wd_o=5, wreg_o=1, stallreq=0.
- SRA, a=4, b=0x80000010 -> 0xF8000001. SRL, same operands -> 0x08000001. SLL, a=0x25 (uses 5) -> 0x00000200.
- MULT, a=0xFFFFFFFD (-3), b=5 -> stallreq high for 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1. A following MFLO gives wdata=0xFFFFFFF1 with no stall.
- MULTU, a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. MULT, a=0x80000000, b=0xFFFFFFFF -> HI=0x00000000, LO=0x80000000.
- rst asserted at RUN cycle 10 of a MULT -> next cycle stallreq=0, HI=LO=0, FSM=IDLE. A new MULT 2x3 then yields LO=6.
- Back-to-back MULT (7x6), MULT (2x2) -> two stall windows of 33 cycles each, separated by one DONE cycle. Final HI=0, LO=4.
